// File: rtl/apb_regfile_param.sv
// APB slave register file: CTRL lock register plus NUM_REGS data registers with wait states and error response.
// Optional byte-lane strobes are enabled by defining APB_REGFILE_PSTRB_EN.
module apb_regfile_param #(
   parameter int                           NUM_REGS    = 4,
   parameter int                           DATA_W      = 32,
   parameter int                           ADDR_W      = 32,
   parameter int                           WAIT_CYCLES = 0,
   parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALS  = {32'h0000_FFFF, 32'hA5A5_0000,
                                                          32'h1234_9876, 32'h5A5A_0000},
   parameter logic [NUM_REGS-1:0]          RO_MASK     = 4'b0001
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_REGFILE_PSTRB_EN
   input  logic [DATA_W/8-1:0] pstrb,
`endif
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   output logic                pready,
   output logic [DATA_W-1:0]   prdata,
   output logic                pslverr
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int                CTRL_RD_W = (NUM_REGS < DATA_W) ? NUM_REGS : DATA_W;
   localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(4 * NUM_REGS);
   // The IDLE cycle already counts as one access cycle, so WAIT holds one cycle fewer than WAIT_CYCLES+1.
   localparam logic [3:0]        WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pready_q, pready_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic              pslverr_q, pslverr_d;
   logic [NUM_REGS-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic              wr_pend_q, wr_pend_d;
   logic              wr_ctrl_q, wr_ctrl_d;
   logic [3:0]        wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] wr_mask_q, wr_mask_d;

   logic              addr_ok;
   logic              is_ctrl;
   logic              locked;
   logic              acc_err;
   logic              respond;
   logic [3:0]        reg_idx;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] wr_mask;

   function automatic logic [DATA_W-1:0] merge_bits(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [DATA_W-1:0] mask);
      merge_bits = (old_v & ~mask) | (new_v & mask);
   endfunction

`ifdef APB_REGFILE_PSTRB_EN
   function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W/8-1:0] strb);
      for (int k = 0; k < DATA_W; k++) begin
         lane_mask[k] = strb[k/8];
      end
   endfunction

   assign wr_mask = lane_mask(pstrb);
`else
   assign wr_mask = '1;
`endif

   assign addr_ok = (paddr[1:0] == 2'b00) && (paddr <= MAX_ADDR);
   assign is_ctrl = (paddr[ADDR_W-1:2] == '0);
   assign reg_idx = 4'(paddr[6:2] - 5'd1);

   always_comb begin
      rd_word = '0;
      locked  = 1'b0;
      if (is_ctrl) begin
         for (int b = 0; b < CTRL_RD_W; b++) begin
            rd_word[b] = ctrl_q[b];
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_idx == 4'(i)) begin
               rd_word = regs_q[i];
               locked  = RO_MASK[i] | ctrl_q[i];
            end
         end
      end
   end

   // CTRL is never locked; only data registers honour RO_MASK and the lock bits.
   assign acc_err = !addr_ok || (pwrite && !is_ctrl && locked);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      ctrl_d    = ctrl_q;
      regs_d    = regs_q;
      wr_pend_d = 1'b0;
      wr_ctrl_d = wr_ctrl_q;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      wr_mask_d = wr_mask_q;
      respond   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (psel && penable) begin
               if (WAIT_CYCLES == 0) begin
                  respond = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = WAIT_INIT;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               respond = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (wr_pend_q) begin
               if (wr_ctrl_q) begin
                  for (int b = 0; b < CTRL_RD_W; b++) begin
                     if (wr_mask_q[b]) ctrl_d[b] = wr_data_q[b];
                  end
               end else begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (wr_idx_q == 4'(i)) regs_d[i] = merge_bits(regs_q[i], wr_data_q, wr_mask_q);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The response and the pending write are both captured from the bus at the same edge.
      if (respond) begin
         pready_d  = 1'b1;
         pslverr_d = acc_err;
         prdata_d  = (!pwrite && !acc_err) ? rd_word : '0;
         wr_pend_d = pwrite && !acc_err;
         wr_ctrl_d = is_ctrl;
         wr_idx_d  = reg_idx;
         wr_data_d = pwdata;
         wr_mask_d = wr_mask;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         ctrl_q    <= '0;
         wr_pend_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         ctrl_q    <= ctrl_d;
         wr_pend_q <= wr_pend_d;
         regs_q    <= regs_d;
      end
   end

   // Write payload needs no reset: it is only consumed when wr_pend_q is set.
   always_ff @(posedge pclk) begin
      wr_ctrl_q <= wr_ctrl_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_param.sv
// Scoreboard bench for apb_regfile_param: directed scenarios plus random accesses against a register-map model.
module tb_apb_regfile_param;
   localparam int WAIT_CYCLES = 3;

   logic        pclk    = 1'b0;
   logic        preset  = 1'b1;
   logic [31:0] paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic [3:0]  pstrb   = 4'hF;
   logic        psel    = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   apb_regfile_param #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
      .pclk    (pclk),
      .preset  (preset),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_REGFILE_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr)
   );

   always #5 pclk = ~pclk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic        mon_en   = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   logic [31:0] m_reg [4];
   logic [3:0]  m_ctrl;
   localparam logic [3:0] M_RO = 4'b0001;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_reg[0] = 32'h5A5A_0000;
      m_reg[1] = 32'h1234_9876;
      m_reg[2] = 32'hA5A5_0000;
      m_reg[3] = 32'h0000_FFFF;
      m_ctrl   = 4'h0;
   endtask

   function automatic logic [31:0] bytes_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
      return r;
   endfunction

   // Register map: 0x00 CTRL, 0x04*(i+1) REG[i]; anything else misaligned or beyond 0x10 errors.
   task automatic model_access(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                               input logic [3:0] strb, output logic [31:0] rd, output logic er);
      logic [31:0] tmp;
      int          i;
      rd = '0;
      er = 1'b0;
      if ((addr % 4) != 0 || addr > 32'd16) begin
         er = 1'b1;
      end else if (addr == 0) begin
         if (wr) begin
            tmp    = bytes_merge({28'h0, m_ctrl}, data, strb);
            m_ctrl = tmp[3:0];
         end else begin
            rd = {28'h0, m_ctrl};
         end
      end else begin
         i = int'(addr / 4) - 1;
         if (wr) begin
            if (M_RO[i] || m_ctrl[i]) er = 1'b1;
            else m_reg[i] = bytes_merge(m_reg[i], data, strb);
         end else begin
            rd = m_reg[i];
         end
      end
   endtask

   task automatic xfer(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                       input logic [3:0] strb, input logic rst_in_done);
      logic [31:0] erd;
      logic        eerr;
      int          n;
      logic        got;
`ifdef APB_REGFILE_PSTRB_EN
      pstrb = strb;
`else
      pstrb = strb | 4'hF;  // without strobes every write is a full word
`endif
      model_access(addr, data, wr, pstrb, erd, eerr);
      exp_q.push_back({eerr, erd});
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 30) begin
         @(posedge pclk); #1;
         n++;
         if (pready) got = 1'b1;
      end
      chk("pready latency", 64'(n), 64'(WAIT_CYCLES + 1));
      if (rst_in_done) begin
         preset = 1'b1;
         @(posedge pclk); #1;
         chk("reset in DONE pready", {63'h0, pready}, 64'h0);
         preset = 1'b0; psel = 1'b0; penable = 1'b0;
         model_reset();
      end else begin
         @(posedge pclk); #1;
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   // Monitor: pops one expected response per pready pulse; outputs must be zero otherwise.
   always @(negedge pclk) begin
      if (mon_en) begin
         if (pready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected pready", 64'h1, 64'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("prdata", {32'h0, prdata}, {32'h0, mon_e[31:0]});
               chk("pslverr", {63'h0, pslverr}, {63'h0, mon_e[32]});
            end
         end else begin
            chk("idle outputs zero", {31'h0, pslverr, prdata}, 64'h0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [31:0] addr_tbl [10];
   logic        saw;

   initial begin
      addr_tbl = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h06, 32'h40, 32'h02, 32'h11};
      model_reset();
      repeat (3) @(posedge pclk);
      #1;
      mon_en = 1'b1;
      chk("reset pready", {63'h0, pready}, 64'h0);
      chk("reset prdata", {32'h0, prdata}, 64'h0);
      chk("reset pslverr", {63'h0, pslverr}, 64'h0);
      preset = 1'b0;

      for (int a = 0; a < 5; a++) xfer(32'(4 * a), 32'h0, 1'b0, 4'hF, 1'b0);

      xfer(32'h08, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0);
      xfer(32'h08, 32'h0, 1'b0, 4'hF, 1'b0);

      xfer(32'h04, 32'h1111_2222, 1'b1, 4'hF, 1'b0);
      xfer(32'h04, 32'h0, 1'b0, 4'hF, 1'b0);
      xfer(32'h00, 32'h4, 1'b1, 4'hF, 1'b0);
      xfer(32'h0C, 32'h3333_4444, 1'b1, 4'hF, 1'b0);
      xfer(32'h00, 32'h0, 1'b0, 4'hF, 1'b0);
      xfer(32'h00, 32'h0, 1'b1, 4'hF, 1'b0);
      xfer(32'h0C, 32'h5555_6666, 1'b1, 4'hF, 1'b0);
      xfer(32'h0C, 32'h0, 1'b0, 4'hF, 1'b0);

      xfer(32'h06, 32'h0, 1'b0, 4'hF, 1'b0);
      xfer(32'h14, 32'h0, 1'b0, 4'hF, 1'b0);
      xfer(32'h40, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b0);
      for (int a = 0; a < 5; a++) xfer(32'(4 * a), 32'h0, 1'b0, 4'hF, 1'b0);

      // Abort: psel drops while the slave is still inserting wait states.
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h7777_7777;
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      psel = 1'b0; penable = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge pclk); #1;
         if (pready) saw = 1'b1;
      end
      chk("abort no pready", {63'h0, saw}, 64'h0);
      xfer(32'h10, 32'h0, 1'b0, 4'hF, 1'b0);

      xfer(32'h0C, 32'hCAFE_0000, 1'b1, 4'hF, 1'b1);
      xfer(32'h0C, 32'h0, 1'b0, 4'hF, 1'b0);

`ifdef APB_REGFILE_PSTRB_EN
      xfer(32'h08, 32'hFFFF_FFFF, 1'b1, 4'b0101, 1'b0);
      xfer(32'h08, 32'h0, 1'b0, 4'hF, 1'b0);
`endif

      for (int t = 0; t < 60; t++) begin
         xfer(addr_tbl[$urandom_range(0, 9)], $urandom, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 1'b0);
      end
      for (int a = 0; a < 5; a++) xfer(32'(4 * a), 32'h0, 1'b0, 4'hF, 1'b0);

      repeat (3) @(posedge pclk);
      #1;
      chk("scoreboard drained", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
